// File: rtl/synth_pkg.sv
// Shared types for the polyphonic voice allocator.
//   NOTE_W_DEF / VEL_W_DEF : default note-number and velocity widths
//   state_t                : allocator FSM states
//   ev_kind_t              : normalised event kind carried through the pipeline
package synth_pkg;

   localparam int unsigned NOTE_W_DEF = 7;
   localparam int unsigned VEL_W_DEF  = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   typedef enum logic {
      EV_ON  = 1'b0,
      EV_OFF = 1'b1
   } ev_kind_t;

endpackage

// File: rtl/poly_voice_pick.sv
// Combinational max-rank picker: returns the candidate voice with the highest
// LRU rank (the oldest) among those set in mask.
//   rank  : flattened rank array, voice v at [v*RANK_W +: RANK_W]
//   mask  : candidate voices
//   idx   : index of the oldest candidate (0 when none)
//   found : at least one candidate was present
module poly_voice_pick #(
   parameter int unsigned VOICES = 4,
   parameter int unsigned RANK_W = 2
) (
   input  logic [VOICES*RANK_W-1:0] rank,
   input  logic [VOICES-1:0]        mask,
   output logic [RANK_W-1:0]        idx,
   output logic                     found
);

   logic [RANK_W-1:0] best;

   // Ranks are a permutation, so a strict compare yields a unique winner.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      best  = '0;
      for (int unsigned v = 0; v < VOICES; v++) begin
         if (mask[v] && (!found || (rank[v*RANK_W +: RANK_W] > best))) begin
            best  = rank[v*RANK_W +: RANK_W];
            idx   = RANK_W'(v);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/poly_voice_alloc.sv
// Polyphonic voice allocator: turns MIDI note-on/off strobes into VOICES
// independent gate/note/velocity slots. Allocation order: same-note reuse,
// oldest free voice, then steal the oldest held voice (LRU ranks).
// Each event takes SCAN + COMMIT; a 1-deep pending buffer absorbs one event
// arriving while busy, further ones are dropped and flagged on overflow.
// Optional feature macro: SUSTAIN_PEDAL_EN (adds the sustain input).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   note_on, note_off : one-cycle strobes, note/velocity valid with them
//   all_off           : one-cycle all-notes-off strobe
//   sustain           : sustain pedal level (SUSTAIN_PEDAL_EN only)
//   gate, retrig      : per-voice gate and one-cycle (re)assign pulse
//   voice_note/vel    : flattened per-voice note and velocity
//   overflow          : one-cycle pulse when an event is dropped
module poly_voice_alloc
   import synth_pkg::*;
#(
   parameter int unsigned VOICES = 4,
   parameter int unsigned NOTE_W = NOTE_W_DEF,
   parameter int unsigned VEL_W  = VEL_W_DEF,
   parameter int unsigned RANK_W = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     note_on,
   input  logic                     note_off,
   input  logic [NOTE_W-1:0]        note,
   input  logic [VEL_W-1:0]         velocity,
   input  logic                     all_off,
`ifdef SUSTAIN_PEDAL_EN
   input  logic                     sustain,
`endif
   output logic [VOICES-1:0]        gate,
   output logic [VOICES*NOTE_W-1:0] voice_note,
   output logic [VOICES*VEL_W-1:0]  voice_vel,
   output logic [VOICES-1:0]        retrig,
   output logic                     overflow
);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_SCAN   = SCAN;
   localparam logic [1:0] ST_COMMIT = COMMIT;

   logic [1:0]               state_q, state_d;
   ev_kind_t                 cur_kind_q, cur_kind_d, pend_kind_q, pend_kind_d, in_kind;
   logic [NOTE_W-1:0]        cur_note_q, cur_note_d, pend_note_q, pend_note_d;
   logic [VEL_W-1:0]         cur_vel_q, cur_vel_d, pend_vel_q, pend_vel_d;
   logic                     pend_valid_q, pend_valid_d;
   logic [VOICES-1:0]        gate_d, retrig_d;
   logic [VOICES*NOTE_W-1:0] voice_note_d;
   logic [VOICES*VEL_W-1:0]  voice_vel_d;
   logic                     overflow_d;
   logic [RANK_W-1:0]        rank_q [VOICES];
   logic [RANK_W-1:0]        rank_d [VOICES];
   logic [VOICES*RANK_W-1:0] rank_flat;

   // Snapshot taken in SCAN and consumed in COMMIT.
   logic [VOICES-1:0]        match_q, match_d;
   logic [RANK_W-1:0]        free_idx_q, free_idx_d, steal_idx_q, steal_idx_d;
   logic                     free_found_q, free_found_d, any_found_q, any_found_d;

   logic [RANK_W-1:0]        pick_free_idx, pick_all_idx, tgt, tgt_rank;
   logic                     pick_free_found, pick_all_found, in_valid, hit;

`ifdef SUSTAIN_PEDAL_EN
   logic [VOICES-1:0]        held_q, held_d;
   logic                     sus_q;
   logic [RANK_W-1:0]        pick_held_idx;
   logic                     pick_held_found;
`endif

   always_comb begin
      for (int unsigned v = 0; v < VOICES; v++) rank_flat[v*RANK_W +: RANK_W] = rank_q[v];
   end

   poly_voice_pick #(.VOICES(VOICES), .RANK_W(RANK_W)) u_pick_free (
      .rank(rank_flat), .mask(~gate), .idx(pick_free_idx), .found(pick_free_found));

   poly_voice_pick #(.VOICES(VOICES), .RANK_W(RANK_W)) u_pick_all (
      .rank(rank_flat), .mask({VOICES{1'b1}}), .idx(pick_all_idx), .found(pick_all_found));

`ifdef SUSTAIN_PEDAL_EN
   // Sustained-but-released voices are stolen before key-down voices.
   poly_voice_pick #(.VOICES(VOICES), .RANK_W(RANK_W)) u_pick_held (
      .rank(rank_flat), .mask(held_q), .idx(pick_held_idx), .found(pick_held_found));
`endif

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      cur_kind_d   = cur_kind_q;
      cur_note_d   = cur_note_q;
      cur_vel_d    = cur_vel_q;
      pend_valid_d = pend_valid_q;
      pend_kind_d  = pend_kind_q;
      pend_note_d  = pend_note_q;
      pend_vel_d   = pend_vel_q;
      gate_d       = gate;
      voice_note_d = voice_note;
      voice_vel_d  = voice_vel;
      retrig_d     = '0;
      overflow_d   = 1'b0;
      rank_d       = rank_q;
      match_d      = match_q;
      free_idx_d   = free_idx_q;
      free_found_d = free_found_q;
      steal_idx_d  = steal_idx_q;
      any_found_d  = any_found_q;
`ifdef SUSTAIN_PEDAL_EN
      held_d       = held_q;
`endif
      tgt          = '0;
      tgt_rank     = '0;
      hit          = 1'b0;

      // Zero-velocity note-on and simultaneous on+off both mean note-off.
      in_valid = note_on | note_off;
      in_kind  = (note_off || (velocity == '0)) ? EV_OFF : EV_ON;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               cur_kind_d = in_kind;
               cur_note_d = note;
               cur_vel_d  = velocity;
               state_d    = ST_SCAN;
            end
         end

         ST_SCAN: begin
            for (int unsigned v = 0; v < VOICES; v++)
               match_d[v] = gate[v] && (voice_note[v*NOTE_W +: NOTE_W] == cur_note_q);
            free_idx_d   = pick_free_idx;
            free_found_d = pick_free_found;
            any_found_d  = pick_free_found | pick_all_found;
            steal_idx_d  = pick_all_idx;
`ifdef SUSTAIN_PEDAL_EN
            if (pick_held_found) steal_idx_d = pick_held_idx;
`endif
            if (in_valid) begin
               if (pend_valid_q) begin
                  overflow_d = 1'b1;
               end else begin
                  pend_valid_d = 1'b1;
                  pend_kind_d  = in_kind;
                  pend_note_d  = note;
                  pend_vel_d   = velocity;
               end
            end
            state_d = ST_COMMIT;
         end

         ST_COMMIT: begin
            for (int unsigned v = 0; v < VOICES; v++) begin
               if (!hit && match_q[v]) begin
                  hit = 1'b1;
                  tgt = RANK_W'(v);
               end
            end
            if (cur_kind_q == EV_ON) begin
               if (!hit) tgt = free_found_q ? free_idx_q : steal_idx_q;
               for (int unsigned v = 0; v < VOICES; v++)
                  if (RANK_W'(v) == tgt) tgt_rank = rank_q[v];
               if (hit || any_found_q) begin
                  // Target becomes newest; everything younger than it ages by one.
                  for (int unsigned v = 0; v < VOICES; v++) begin
                     if (RANK_W'(v) == tgt) begin
                        gate_d[v]                        = 1'b1;
                        voice_note_d[v*NOTE_W +: NOTE_W] = cur_note_q;
                        voice_vel_d[v*VEL_W +: VEL_W]    = cur_vel_q;
                        retrig_d[v]                      = 1'b1;
                        rank_d[v]                        = '0;
`ifdef SUSTAIN_PEDAL_EN
                        held_d[v]                        = 1'b0;
`endif
                     end else if (rank_q[v] < tgt_rank) begin
                        rank_d[v] = rank_q[v] + RANK_W'(1);
                     end
                  end
               end
            end else begin
               // Note and velocity are kept so release tails keep their pitch.
               for (int unsigned v = 0; v < VOICES; v++) begin
                  if (match_q[v]) begin
`ifdef SUSTAIN_PEDAL_EN
                     if (sustain) held_d[v] = 1'b1;
                     else         gate_d[v] = 1'b0;
`else
                     gate_d[v] = 1'b0;
`endif
                  end
               end
            end

            // An event arriving now goes straight to cur when pending is empty.
            if (pend_valid_q) begin
               cur_kind_d   = pend_kind_q;
               cur_note_d   = pend_note_q;
               cur_vel_d    = pend_vel_q;
               pend_valid_d = 1'b0;
               state_d      = ST_SCAN;
               if (in_valid) overflow_d = 1'b1;
            end else if (in_valid) begin
               cur_kind_d = in_kind;
               cur_note_d = note;
               cur_vel_d  = velocity;
               state_d    = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

`ifdef SUSTAIN_PEDAL_EN
      // Pedal release drops every voice that was only being sustained.
      if (sus_q && !sustain) begin
         gate_d = gate_d & ~held_d;
         held_d = '0;
      end
`endif

      // all_off wins over any in-flight commit and flushes the pipeline.
      if (all_off) begin
         gate_d       = '0;
         voice_note_d = voice_note;
         voice_vel_d  = voice_vel;
         retrig_d     = '0;
         overflow_d   = 1'b0;
         rank_d       = rank_q;
         pend_valid_d = 1'b0;
         state_d      = ST_IDLE;
`ifdef SUSTAIN_PEDAL_EN
         held_d       = '0;
`endif
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cur_kind_q   <= EV_OFF;
         cur_note_q   <= '0;
         cur_vel_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_kind_q  <= EV_OFF;
         pend_note_q  <= '0;
         pend_vel_q   <= '0;
         gate         <= '0;
         voice_note   <= '0;
         voice_vel    <= '0;
         retrig       <= '0;
         overflow     <= 1'b0;
         for (int unsigned v = 0; v < VOICES; v++) rank_q[v] <= RANK_W'(v);
         match_q      <= '0;
         free_idx_q   <= '0;
         free_found_q <= 1'b0;
         steal_idx_q  <= '0;
         any_found_q  <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
         held_q       <= '0;
         sus_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cur_kind_q   <= cur_kind_d;
         cur_note_q   <= cur_note_d;
         cur_vel_q    <= cur_vel_d;
         pend_valid_q <= pend_valid_d;
         pend_kind_q  <= pend_kind_d;
         pend_note_q  <= pend_note_d;
         pend_vel_q   <= pend_vel_d;
         gate         <= gate_d;
         voice_note   <= voice_note_d;
         voice_vel    <= voice_vel_d;
         retrig       <= retrig_d;
         overflow     <= overflow_d;
         rank_q       <= rank_d;
         match_q      <= match_d;
         free_idx_q   <= free_idx_d;
         free_found_q <= free_found_d;
         steal_idx_q  <= steal_idx_d;
         any_found_q  <= any_found_d;
`ifdef SUSTAIN_PEDAL_EN
         held_q       <= held_d;
         sus_q        <= sustain;
`endif
      end
   end

endmodule

// File: tb/tb_poly_voice_alloc.sv
// Bench for poly_voice_alloc (VOICES=4): directed stimulus, a behavioural
// allocator model (LRU kept as an oldest-first queue, events timed from the
// two-stage pipeline rules), a per-cycle compare against that model, and a
// few literal expectations. Sustain checks appear when SUSTAIN_PEDAL_EN is set.
module tb_poly_voice_alloc;
   import synth_pkg::*;

   localparam int unsigned V  = 4;
   localparam int unsigned NW = 7;
   localparam int unsigned VW = 7;
   localparam int unsigned RW = 2;

   logic          clk, rst, note_on, note_off, all_off;
   logic [NW-1:0] note;
   logic [VW-1:0] velocity;
`ifdef SUSTAIN_PEDAL_EN
   logic          sustain;
`endif
   logic [V-1:0]    gate, retrig;
   logic [V*NW-1:0] voice_note;
   logic [V*VW-1:0] voice_vel;
   logic            overflow;

   poly_voice_alloc #(.VOICES(V), .NOTE_W(NW), .VEL_W(VW), .RANK_W(RW)) dut (
      .clk(clk), .rst(rst), .note_on(note_on), .note_off(note_off),
      .note(note), .velocity(velocity), .all_off(all_off),
`ifdef SUSTAIN_PEDAL_EN
      .sustain(sustain),
`endif
      .gate(gate), .voice_note(voice_note), .voice_vel(voice_vel),
      .retrig(retrig), .overflow(overflow));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit off;
      int nt;
      int vl;
      int commit;
   } ev_t;

   bit  m_gate [V];
   bit  m_held [V];
   int  m_note [V];
   int  m_vel  [V];
   bit  m_retrig [V];
   bit  m_ovf;
   int  lru[$];          // oldest first
   ev_t mq[$];
   int  cyc, last_commit, pend_until;
   bit  m_sus_q;

   logic [V-1:0]    exp_gate, exp_retrig;
   logic [V*NW-1:0] exp_note;
   logic [V*VW-1:0] exp_vel;
   logic            exp_ovf;

   function automatic bit sus_in();
`ifdef SUSTAIN_PEDAL_EN
      return sustain;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void publish();
      for (int v = 0; v < V; v++) begin
         exp_gate[v]            = m_gate[v];
         exp_retrig[v]          = m_retrig[v];
         exp_note[v*NW +: NW]   = NW'(m_note[v]);
         exp_vel[v*VW +: VW]    = VW'(m_vel[v]);
      end
      exp_ovf = m_ovf;
   endfunction

   function automatic void model_reset();
      for (int v = 0; v < V; v++) begin
         m_gate[v] = 0; m_held[v] = 0; m_note[v] = 0; m_vel[v] = 0; m_retrig[v] = 0;
      end
      m_ovf = 0;
      lru.delete();
      for (int v = V - 1; v >= 0; v--) lru.push_back(v);
      mq.delete();
      cyc = 0; last_commit = -10; pend_until = -10; m_sus_q = 0;
      publish();
   endfunction

   function automatic void apply(input ev_t ev);
      int t, pos;
      t = -1;
      if (!ev.off) begin
         for (int v = 0; v < V; v++) if (t < 0 && m_gate[v] && m_note[v] == ev.nt) t = v;
         foreach (lru[i]) if (t < 0 && !m_gate[lru[i]]) t = lru[i];
         foreach (lru[i]) if (t < 0 && m_held[lru[i]]) t = lru[i];
         if (t < 0) t = lru[0];
         m_gate[t] = 1; m_note[t] = ev.nt; m_vel[t] = ev.vl; m_retrig[t] = 1; m_held[t] = 0;
         pos = 0;
         foreach (lru[i]) if (lru[i] == t) pos = i;
         lru.delete(pos);
         lru.push_back(t);
      end else begin
         for (int v = 0; v < V; v++)
            if (m_gate[v] && m_note[v] == ev.nt) begin
               if (sus_in()) m_held[v] = 1;
               else          m_gate[v] = 0;
            end
      end
   endfunction

   function automatic void model_step();
      ev_t ev;
      int  start;
      cyc++;
      for (int v = 0; v < V; v++) m_retrig[v] = 0;
      m_ovf = 0;
      if (all_off) begin
         for (int v = 0; v < V; v++) begin m_gate[v] = 0; m_held[v] = 0; end
         mq.delete();
         last_commit = -10; pend_until = -10;
      end else begin
         if (mq.size() > 0 && mq[0].commit == cyc) begin
            apply(mq[0]);
            void'(mq.pop_front());
         end
         if (note_on || note_off) begin
            if (pend_until >= cyc) m_ovf = 1;
            else begin
               start = (last_commit > cyc) ? last_commit : cyc;
               if (start > cyc) pend_until = start;
               ev.off = note_off || (velocity == 0);
               ev.nt = int'(note); ev.vl = int'(velocity);
               ev.commit = start + 2;
               last_commit = ev.commit;
               mq.push_back(ev);
            end
         end
      end
      if (m_sus_q && !sus_in()) begin
         for (int v = 0; v < V; v++) begin
            if (m_held[v]) m_gate[v] = 0;
            m_held[v] = 0;
         end
      end
      m_sus_q = sus_in();
      publish();
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      if (checking && !rst) begin
         chk("cyc_gate",     64'(gate),       64'(exp_gate));
         chk("cyc_note",     64'(voice_note), 64'(exp_note));
         chk("cyc_vel",      64'(voice_vel),  64'(exp_vel));
         chk("cyc_retrig",   64'(retrig),     64'(exp_retrig));
         chk("cyc_overflow", 64'(overflow),   64'(exp_ovf));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit on, input bit off, input int n, input int vl, input bit ao);
      @(negedge clk);
      note_on = on; note_off = off; note = NW'(n); velocity = VW'(vl); all_off = ao;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0);
   endtask

   // Note-on, then check that retrig shows up exactly three edges after the strobe.
   task automatic on_retrig(input string name, input int n, input int vl, input logic [V-1:0] exp_rt);
      drive(1, 0, n, vl, 0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk({name, "_rt_early"}, 64'(retrig), 64'(0));
      @(negedge clk);
      chk({name, "_rt"}, 64'(retrig), 64'(exp_rt));
   endtask

   logic [NW-1:0] nslice;
   logic [VW-1:0] vslice;
   int tab_on  [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
   int tab_off [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
   int tab_n   [9] = '{50, 51, 52, 53, 54, 52, 55, 51, 56};
   int tab_v   [9] = '{10, 11, 12, 13, 14, 15, 16, 0, 17};

   initial begin
      rst = 1'b1; note_on = 0; note_off = 0; note = '0; velocity = '0; all_off = 0;
`ifdef SUSTAIN_PEDAL_EN
      sustain = 0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_gate", 64'(gate), 64'(0));
      chk("rst_note", 64'(voice_note), 64'(0));
      chk("rst_retrig_ovf", 64'({retrig, overflow}), 64'(0));
      rst = 1'b0;
      checking = 1'b1;

      // Fresh allocation walks the oldest free voices: 3, 2, 1.
      on_retrig("t1_60", 60, 100, 4'b1000);
      on_retrig("t1_62", 62, 101, 4'b0100);
      on_retrig("t1_64", 64, 102, 4'b0010);
      idle(2);
      chk("t1_gate", 64'(gate), 64'(4'b1110));
      chk("t1_notes", 64'(voice_note), 64'({7'd60, 7'd62, 7'd64, 7'd0}));
      chk("t1_model", 64'(exp_note), 64'({7'd60, 7'd62, 7'd64, 7'd0}));

      // Fill the last voice, then steal the oldest (voice 3, note 60).
      on_retrig("t2_65", 65, 90, 4'b0001);
      on_retrig("t2_steal", 67, 80, 4'b1000);
      idle(2);
      chk("t2_gate", 64'(gate), 64'(4'b1111));
      chk("t2_notes", 64'(voice_note), 64'({7'd67, 7'd62, 7'd64, 7'd65}));

      // all_off, then same-note reuse updates velocity only.
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      chk("t3_alloff", 64'(gate), 64'(0));
      on_retrig("t3_60a", 60, 100, 4'b0100);
      on_retrig("t3_60b", 60, 40, 4'b0100);
      idle(2);
      chk("t3_gate", 64'(gate), 64'(4'b0100));
      vslice = voice_vel[2*VW +: VW];
      chk("t3_vel", 64'(vslice), 64'(40));

      // Zero-velocity note-on releases; unheld note-off does nothing.
      on_retrig("t4_72", 72, 90, 4'b0010);
      drive(1, 0, 72, 0, 0);
      idle(4);
      chk("t4_gate", 64'(gate), 64'(4'b0100));
      nslice = voice_note[1*NW +: NW];
      chk("t4_note_kept", 64'(nslice), 64'(72));
      drive(0, 1, 50, 0, 0);
      idle(4);
      chk("t4_unheld", 64'(gate), 64'(4'b0100));

      // Three back-to-back strobes: third one overflows.
      drive(1, 0, 40, 20, 0);
      drive(1, 0, 41, 21, 0);
      drive(1, 0, 42, 22, 0);
      drive(0, 0, 0, 0, 0);
      chk("t5_ovf", 64'(overflow), 64'(1));
      drive(0, 0, 0, 0, 0);
      chk("t5_ovf_end", 64'(overflow), 64'(0));
      idle(4);
      chk("t5_gate", 64'(gate), 64'(4'b1101));
      chk("t5_notes", 64'(voice_note), 64'({7'd41, 7'd60, 7'd72, 7'd40}));

      // all_off while the event is in SCAN: nothing commits.
      drive(1, 0, 43, 23, 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0);
      chk("t6_gate", 64'(gate), 64'(0));
      idle(4);
      chk("t6_nocommit", 64'(gate), 64'(0));
      nslice = voice_note[1*NW +: NW];
      chk("t6_note1", 64'(nslice), 64'(72));

      // One event every two cycles, with a steal, on+off pair and a zero-velocity off.
      for (int i = 0; i < 9; i++) begin
         drive(tab_on[i][0], tab_off[i][0], tab_n[i], tab_v[i], 0);
         drive(0, 0, 0, 0, 0);
      end
      idle(3);
      chk("t7_gate", 64'(gate), 64'(4'b1111));
      chk("t7_notes", 64'(voice_note), 64'({7'd53, 7'd54, 7'd56, 7'd55}));

      // Reset in the middle of an event aborts it.
      drive(1, 0, 70, 30, 0);
      @(negedge clk);
      note_on = 0;
      rst = 1'b1;
      @(negedge clk);
      chk("t8_rst_gate", 64'(gate), 64'(0));
      chk("t8_rst_note", 64'(voice_note), 64'(0));
      rst = 1'b0;
      idle(4);
      chk("t8_after", 64'(gate), 64'(0));

`ifdef SUSTAIN_PEDAL_EN
      @(negedge clk);
      sustain = 1'b1;
      on_retrig("t9_on", 60, 50, 4'b1000);
      drive(0, 1, 60, 0, 0);
      idle(4);
      chk("t9_sustained", 64'(gate), 64'(4'b1000));
      @(negedge clk);
      sustain = 1'b0;
      @(negedge clk);
      chk("t9_release", 64'(gate), 64'(0));
`endif

      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
